// File: rtl/picorisc_pkg.sv
// Shared widths, call-stack depth and fetch FSM encoding for the picorisc fetch stage.
package picorisc_pkg;
  localparam int P_WIDTH     = 5;
  localparam int I_WIDTH     = 20;
  localparam int STACK_DEPTH = 4;

  typedef enum logic [1:0] {IDLE, RUN, HALT} fetch_state_t;
endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO. A push when full and a pop when empty are both ignored here;
// the caller decides how to flag them. top reads as 0 when empty.
module ret_stack #(
  parameter int W     = 5,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);
  localparam int AW  = $clog2(DEPTH);
  localparam int SPW = $clog2(DEPTH + 1);

  logic [W-1:0]   mem [DEPTH];
  logic [SPW-1:0] sp;

  assign full  = (sp == SPW'(DEPTH));
  assign empty = (sp == '0);
  assign top   = empty ? '0 : mem[AW'(sp - 1'b1)];

  always_ff @(posedge clk) begin
    if (rst)                sp <= '0;
    else if (pop && !empty) sp <= sp - 1'b1;
    else if (push && !full) sp <= sp + 1'b1;
  end

  // Storage carries no reset; sp alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (!rst && !pop && push && !full) mem[AW'(sp)] <= din;
  end
endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: PC, one-cycle registered instruction, IDLE/RUN/HALT control.
// Call/return stack present only when INSTR_FETCH_CALL_STACK_EN is defined.
module instr_fetch
  import picorisc_pkg::*;
#(
  parameter int p = P_WIDTH,
  parameter int i = I_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  output logic [p-1:0] addr,
  input  logic [i-1:0] instr_code,
  input  logic         stall,
  input  logic         branch,
  input  logic [p-1:0] target,
  input  logic         call,
  input  logic         ret,
  input  logic         halt,
  output logic [i-1:0] instr,
  output logic [p-1:0] instr_pc,
  output logic         instr_valid,
  output logic         stack_err
);
  fetch_state_t state, state_nxt;
  logic [p-1:0] pc, pc_nxt, pc_inc, stk_top;
  logic         adv, do_call, do_ret, redirect;

  assign addr   = pc;
  assign adv    = (state == RUN) && !stall;
  assign pc_inc = pc + 1'b1;

`ifdef INSTR_FETCH_CALL_STACK_EN
  logic stk_full, stk_empty;

  // ret wins over call; a simultaneous call is dropped entirely.
  assign do_ret  = adv && ret;
  assign do_call = adv && call && !ret;

  ret_stack #(.W(p), .DEPTH(STACK_DEPTH)) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (do_call),
    .pop   (do_ret),
    .din   (pc_inc),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) stack_err <= 1'b0;
    else if ((do_call && stk_full) || (do_ret && stk_empty)) stack_err <= 1'b1;
  end
`else
  logic unused_stack_in;
  assign unused_stack_in = call ^ ret;
  assign do_ret    = 1'b0;
  assign do_call   = 1'b0;
  assign stk_top   = '0;
  assign stack_err = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    redirect  = 1'b0;
    case (state)
      IDLE: state_nxt = RUN;
      RUN: if (!stall) begin
        if (halt) state_nxt = HALT;
        redirect = do_ret || do_call || branch;
        if (do_ret)                  pc_nxt = stk_top;
        else if (do_call || branch)  pc_nxt = target;
        else                         pc_nxt = pc_inc;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      if (adv) begin
        instr       <= instr_code;
        instr_pc    <= pc;
        instr_valid <= !redirect && !halt;
      end else if (state != RUN) begin
        instr_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed table, hand sequences and random stimulus
// checked against a queue-based reference model.
module tb_instr_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  addr;
  logic [19:0] instr_code;
  logic        stall = 0, branch = 0, call = 0, ret = 0, halt = 0;
  logic [4:0]  target = '0;
  logic [19:0] instr;
  logic [4:0]  instr_pc;
  logic        instr_valid, stack_err;

  logic [19:0] rom [32];
  assign instr_code = rom[addr];

  instr_fetch dut (
    .clk(clk), .rst(rst), .addr(addr), .instr_code(instr_code),
    .stall(stall), .branch(branch), .target(target), .call(call), .ret(ret),
    .halt(halt), .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .stack_err(stack_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // reference model: m_state 0=idle 1=run 2=halt
  int m_pc, m_ipc, m_valid, m_err, m_state;
  int m_instr;
  int stk[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model(input bit r, s, b, input int t, input bit c, rt, h);
    int np;
    bit redir;
    redir = 0;
    np = 0;
    if (r) begin
      m_pc = 0; m_ipc = 0; m_valid = 0; m_err = 0; m_state = 0; m_instr = 0;
      stk.delete();
    end else if (m_state == 0) begin
      m_state = 1;
    end else if (m_state == 1 && !s) begin
      m_instr = int'(rom[m_pc]);
      m_ipc = m_pc;
`ifdef INSTR_FETCH_CALL_STACK_EN
      if (rt) begin
        redir = 1;
        if (stk.size() == 0) begin np = 0; m_err = 1; end
        else np = stk.pop_back();
      end else if (c) begin
        redir = 1;
        if (stk.size() < 4) stk.push_back((m_pc + 1) % 32);
        else m_err = 1;
        np = t;
      end else
`endif
      if (b) begin redir = 1; np = t; end
      else np = (m_pc + 1) % 32;
      m_valid = (!redir && !h) ? 1 : 0;
      if (h) m_state = 2;
      m_pc = np;
    end
  endtask

  task automatic step(input bit r, s, b, input int t, input bit c, rt, h);
    rst = r; stall = s; branch = b; target = 5'(t); call = c; ret = rt; halt = h;
    @(posedge clk);
    model(r, s, b, t, c, rt, h);
    #1;
    chk("addr", int'(addr), m_pc);
    chk("instr", int'(instr), m_instr);
    chk("instr_pc", int'(instr_pc), m_ipc);
    chk("instr_valid", int'(instr_valid), m_valid);
    chk("stack_err", int'(stack_err), m_err);
  endtask

  task automatic idle_step();
    step(0, 0, 0, 0, 0, 0, 0);
  endtask

  typedef struct {
    bit r, s, b;
    int t;
    bit h;
    int ea, ev, eip;
  } vec_t;
  vec_t tbl[19];

  initial begin
    for (int k = 0; k < 32; k++) rom[k] = 20'($urandom);

    // reset, branch at PC=5, stall with branch held, halt at PC=7, reset from HALT
    tbl[0]  = '{1, 0, 0, 0,  0, 0,  0, 0};
    tbl[1]  = '{0, 0, 0, 0,  0, 0,  0, 0};
    tbl[2]  = '{0, 0, 0, 0,  0, 1,  1, 0};
    tbl[3]  = '{0, 0, 0, 0,  0, 2,  1, 1};
    tbl[4]  = '{0, 0, 0, 0,  0, 3,  1, 2};
    tbl[5]  = '{0, 0, 0, 0,  0, 4,  1, 3};
    tbl[6]  = '{0, 0, 0, 0,  0, 5,  1, 4};
    tbl[7]  = '{0, 0, 1, 20, 0, 20, 0, 5};
    tbl[8]  = '{0, 0, 0, 0,  0, 21, 1, 20};
    tbl[9]  = '{0, 1, 1, 3,  0, 21, 1, 20};
    tbl[10] = '{0, 1, 1, 3,  0, 21, 1, 20};
    tbl[11] = '{0, 1, 1, 3,  0, 21, 1, 20};
    tbl[12] = '{0, 0, 0, 0,  0, 22, 1, 21};
    tbl[13] = '{0, 0, 1, 7,  0, 7,  0, 22};
    tbl[14] = '{0, 0, 0, 0,  1, 8,  0, 7};
    tbl[15] = '{0, 0, 0, 0,  0, 8,  0, 7};
    tbl[16] = '{0, 0, 1, 3,  0, 8,  0, 7};
    tbl[17] = '{1, 0, 0, 0,  0, 0,  0, 0};
    tbl[18] = '{0, 0, 0, 0,  0, 0,  0, 0};

    for (int k = 0; k < 19; k++) begin
      step(tbl[k].r, tbl[k].s, tbl[k].b, tbl[k].t, 0, 0, tbl[k].h);
      chk($sformatf("tbl%0d_addr", k), int'(addr), tbl[k].ea);
      chk($sformatf("tbl%0d_valid", k), int'(instr_valid), tbl[k].ev);
      chk($sformatf("tbl%0d_ipc", k), int'(instr_pc), tbl[k].eip);
    end

    // free run with wrap: cycle c after reset
    step(1, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 34; c++) begin
      if (c > 0) idle_step();
      chk($sformatf("run%0d_addr", c), int'(addr), (c == 0) ? 0 : (c - 1) % 32);
      chk($sformatf("run%0d_valid", c), int'(instr_valid), (c >= 2) ? 1 : 0);
      if (c >= 2) chk($sformatf("run%0d_ipc", c), int'(instr_pc), (c - 2) % 32);
    end

`ifdef INSTR_FETCH_CALL_STACK_EN
    // call at PC=3, ret at PC=12
    step(1, 0, 0, 0, 0, 0, 0);
    repeat (4) idle_step();
    chk("call_pre_addr", int'(addr), 3);
    step(0, 0, 0, 10, 1, 0, 0);
    chk("call_addr", int'(addr), 10);
    chk("call_bubble", int'(instr_valid), 0);
    idle_step(); idle_step();
    chk("ret_pre_addr", int'(addr), 12);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("ret_addr", int'(addr), 4);
    chk("ret_err", int'(stack_err), 0);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("underflow_addr", int'(addr), 0);
    chk("underflow_err", int'(stack_err), 1);

    // five nested calls, five returns
    step(1, 0, 0, 0, 0, 0, 0);
    idle_step();
    for (int k = 0; k < 5; k++) step(0, 0, 0, 10, 1, 0, 0);
    chk("overflow_err", int'(stack_err), 1);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, 0, 1, 0);
    chk("ret4_addr", int'(addr), 1);
    step(0, 0, 0, 0, 1, 1, 0);
    chk("ret5_addr", int'(addr), 0);
    chk("ret5_err", int'(stack_err), 1);
`else
    step(1, 0, 0, 0, 0, 0, 0);
    idle_step();
    step(0, 0, 0, 10, 1, 0, 0);
    chk("nocall_addr", int'(addr), 1);
    chk("nocall_valid", int'(instr_valid), 1);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("noret_addr", int'(addr), 2);
    chk("noret_err", int'(stack_err), 0);
`endif

    // random traffic against the model
    for (int k = 0; k < 600; k++) begin
      step(($urandom_range(63) == 0), ($urandom_range(3) == 0),
           ($urandom_range(7) == 0), int'($urandom_range(31)),
           ($urandom_range(5) == 0), ($urandom_range(5) == 0),
           ($urandom_range(49) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
